sysid_checker: RTL and testbench

- Avalon-MM read master that sits directly downstream of the system-ID slave.
- Reads the ID word (address 0) and the timestamp word (address 1), latches both and compares them against expected values.
- Raises pass/fail status to software-visible logic and to an LED/boot-hold path.
- Runs once after reset (optional) and on demand; optionally re-checks periodically.

---
 rtl/sysid_checker.sv | 135 +++++++++++++
 tb/tb_sysid_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Avalon-MM reader that fetches sysid ID/timestamp words and compares them against expected values.
// Latency: start to done = 4 + 2*READ_LATENCY cycles; no backpressure, start is dropped while busy.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0001_2345,
  parameter logic [31:0] EXPECTED_TS    = 32'h5354_22F6,
  parameter int unsigned READ_LATENCY   = 0,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned RECHECK_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        valid,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WT_ID   = 3'd2,
    RD_TS   = 3'd3,
    WT_TS   = 3'd4,
    CMP     = 3'd5,
    DONE_ST = 3'd6
  } state_t;

  localparam int RC_W = (RECHECK_PERIOD > 0) ? $clog2(RECHECK_PERIOD + 1) : 1;
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RECHECK_PERIOD);
  localparam logic [RC_W-1:0] RC_LAST = (RECHECK_PERIOD > 0) ? RC_W'(RECHECK_PERIOD - 1) : '0;
  localparam logic [1:0]      LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam bit              NO_WAIT  = (READ_LATENCY == 0);
  localparam bit              RC_EN    = (RECHECK_PERIOD > 0);

  state_t            state;
  state_t            nxt;
  logic              first_q;
  logic [1:0]        lat_cnt;
  logic [RC_W-1:0]   rc_cnt;
  logic [31:0]       id_cap;
  logic [31:0]       ts_cap;
  logic              recheck_hit;
  logic              launch;
  logic              lat_last;
  logic              cap_id;
  logic              cap_ts;

  // The increment that takes the counter to RECHECK_PERIOD is the cycle that launches the re-check.
  assign recheck_hit = RC_EN && valid && (state == IDLE) && (rc_cnt == RC_LAST);
  assign launch      = start || (AUTO_START && first_q) || recheck_hit;
  assign lat_last    = (lat_cnt == LAT_LAST);
  assign cap_id      = ((state == RD_ID) && NO_WAIT) || ((state == WT_ID) && lat_last);
  assign cap_ts      = ((state == RD_TS) && NO_WAIT) || ((state == WT_TS) && lat_last);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (launch) nxt = RD_ID;
      RD_ID:   nxt = NO_WAIT ? RD_TS : WT_ID;
      WT_ID:   if (lat_last) nxt = RD_TS;
      RD_TS:   nxt = NO_WAIT ? CMP : WT_TS;
      WT_TS:   if (lat_last) nxt = CMP;
      CMP:     nxt = DONE_ST;
      DONE_ST: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    read    = (state == RD_ID) || (state == RD_TS);
    address = (state == RD_TS);
    busy    = (state != IDLE);
    done    = (state == DONE_ST);
  end

  // Captured words sit in shadow registers so the visible results only move in CMP.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      first_q  <= 1'b1;
      lat_cnt  <= 2'd0;
      rc_cnt   <= '0;
      id_cap   <= 32'd0;
      ts_cap   <= 32'd0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      pass     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      first_q <= 1'b0;

      if ((state == WT_ID) || (state == WT_TS)) begin
        lat_cnt <= lat_last ? 2'd0 : lat_cnt + 2'd1;
      end else begin
        lat_cnt <= 2'd0;
      end

      if (cap_id) id_cap <= readdata;
      if (cap_ts) ts_cap <= readdata;

      if (state == CMP) begin
        id_value <= id_cap;
        ts_value <= ts_cap;
        id_ok    <= (id_cap == EXPECTED_ID);
        ts_ok    <= (ts_cap == EXPECTED_TS);
        pass     <= (id_cap == EXPECTED_ID) && (ts_cap == EXPECTED_TS);
        valid    <= 1'b1;
      end

      if (state == DONE_ST) begin
        rc_cnt <= '0;
      end else if (RC_EN && valid && (state == IDLE) && (rc_cnt != RC_MAX)) begin
        rc_cnt <= rc_cnt + RC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: four instances (latency 0/2/0/3, one with re-check, one without auto-start)
// each fed by a behavioural sysid slave; table vectors, hand sequences and a randomized model check.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0001_2345;
  localparam logic [31:0] EXP_TS = 32'h5354_22F6;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;
  localparam int NI = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [NI-1:0]        rst_n, start, rd, addr, busy, done, id_ok, ts_ok, pass, valid;
  logic [NI-1:0][31:0]  rdata, id_v, ts_v, id_w, ts_w;
  logic [NI-1:0][3:0]   rd_h, addr_h;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic int lat_of(input int i);
    return (i == 1) ? 2 : ((i == 3) ? 3 : 0);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sysid_checker #(
      .EXPECTED_ID    (EXP_ID),
      .EXPECTED_TS    (EXP_TS),
      .READ_LATENCY   ((g == 1) ? 2 : ((g == 3) ? 3 : 0)),
      .AUTO_START     ((g == 3) ? 1'b0 : 1'b1),
      .RECHECK_PERIOD ((g == 2) ? 10 : 0)
    ) u_dut (
      .clock    (clock),
      .reset_n  (rst_n[g]),
      .start    (start[g]),
      .address  (addr[g]),
      .read     (rd[g]),
      .readdata (rdata[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .id_ok    (id_ok[g]),
      .ts_ok    (ts_ok[g]),
      .pass     (pass[g]),
      .valid    (valid[g]),
      .id_value (id_v[g]),
      .ts_value (ts_v[g])
    );
  end

  // Slave: data appears exactly READ_LATENCY cycles after the strobe, junk otherwise.
  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      rd_h[i]   <= {rd_h[i][2:0], rd[i]};
      addr_h[i] <= {addr_h[i][2:0], addr[i]};
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NI; i++) begin
      if (lat_of(i) == 0)
        rdata[i] = rd[i] ? (addr[i] ? ts_w[i] : id_w[i]) : JUNK;
      else
        rdata[i] = rd_h[i][lat_of(i)-1] ? (addr_h[i][lat_of(i)-1] ? ts_w[i] : id_w[i]) : JUNK;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int i, input int maxc, output int n);
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (done[i]) begin
        n = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic        st0;
    logic [31:0] id0;
    logic        r0, a0, b0, d0, p0, v0;
    logic        r1, d1, p1;
  } vec_t;

  vec_t tbl [16];

  int          n, cyc, done_at, rdcnt;
  bit          pend;
  logic        prev_rd;
  logic [31:0] m_id, m_ts;

  initial begin
    // Reset release / auto check on inst 0 (L=0) and inst 1 (L=2), then a start-spam check on inst 0.
    tbl[0]  = '{1'b0, EXP_ID,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, EXP_ID,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, EXP_ID,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h0001_2346, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'h0001_2346, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 32'h0001_2346, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 32'h0001_2346, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 32'h0001_2346, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 32'h0001_2346, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = '0;
    start = '0;
    id_w  = {NI{EXP_ID}};
    ts_w  = {NI{EXP_TS}};
    repeat (3) tick();

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_busy%0d", i), busy[i], 1'b0);
      chk($sformatf("reset_read%0d", i), rd[i], 1'b0);
      chk($sformatf("reset_valid%0d", i), valid[i], 1'b0);
      chk($sformatf("reset_pass%0d", i), pass[i], 1'b0);
      chk($sformatf("reset_id_value%0d", i), id_v[i], 32'd0);
    end

    rst_n = 4'b1011;
    for (int k = 0; k < 16; k++) begin
      start[0] = tbl[k].st0;
      id_w[0]  = tbl[k].id0;
      tick();
      chk($sformatf("row%0d_read0", k + 1), rd[0], tbl[k].r0);
      if (tbl[k].r0) chk($sformatf("row%0d_addr0", k + 1), addr[0], tbl[k].a0);
      chk($sformatf("row%0d_busy0", k + 1), busy[0], tbl[k].b0);
      chk($sformatf("row%0d_done0", k + 1), done[0], tbl[k].d0);
      chk($sformatf("row%0d_pass0", k + 1), pass[0], tbl[k].p0);
      chk($sformatf("row%0d_valid0", k + 1), valid[0], tbl[k].v0);
      chk($sformatf("row%0d_read1", k + 1), rd[1], tbl[k].r1);
      chk($sformatf("row%0d_done1", k + 1), done[1], tbl[k].d1);
      chk($sformatf("row%0d_pass1", k + 1), pass[1], tbl[k].p1);
      chk($sformatf("row%0d_noauto_busy3", k + 1), busy[3], 1'b0);
      if (k == 9) chk("auto_id_value0", id_v[0], EXP_ID);
    end
    start[0] = 1'b0;
    chk("badid_id_ok", id_ok[0], 1'b0);
    chk("badid_ts_ok", ts_ok[0], 1'b1);
    chk("badid_id_value", id_v[0], 32'h0001_2346);
    chk("lat2_id_value", id_v[1], EXP_ID);
    chk("lat2_ts_value", ts_v[1], EXP_TS);
    chk("noauto_valid3", valid[3], 1'b0);

    // Periodic re-check on inst 2 with the timestamp broken after the first pass.
    rst_n[2] = 1'b1;
    wait_done(2, 20, n);
    chk("rc_first_done_cycles", n, 4);
    chk("rc_first_pass", pass[2], 1'b1);
    ts_w[2] = 32'd0;
    n = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      chk($sformatf("rc_idle_done_c%0d", c), done[2], 1'b0);
      if (rd[2]) begin
        n = c;
        break;
      end
    end
    chk("rc_restart_cycles", n, 11);
    wait_done(2, 10, n);
    chk("rc_second_done_cycles", n, 3);
    chk("rc_second_ts_ok", ts_ok[2], 1'b0);
    chk("rc_second_id_ok", id_ok[2], 1'b1);
    chk("rc_second_pass", pass[2], 1'b0);
    chk("rc_second_ts_value", ts_v[2], 32'd0);

    // Reset in WT_TS on inst 1 (L=2), then an auto-started check after release.
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (4) tick();
    chk("abort_pre_busy", busy[1], 1'b1);
    chk("abort_pre_valid", valid[1], 1'b1);
    rst_n[1] = 1'b0;
    tick();
    chk("abort_busy", busy[1], 1'b0);
    chk("abort_done", done[1], 1'b0);
    chk("abort_read", rd[1], 1'b0);
    chk("abort_addr", addr[1], 1'b0);
    chk("abort_valid", valid[1], 1'b0);
    chk("abort_pass", pass[1], 1'b0);
    chk("abort_id_ok", id_ok[1], 1'b0);
    chk("abort_ts_ok", ts_ok[1], 1'b0);
    chk("abort_id_value", id_v[1], 32'd0);
    chk("abort_ts_value", ts_v[1], 32'd0);
    tick();
    chk("abort_hold_done", done[1], 1'b0);
    rst_n[1] = 1'b1;
    wait_done(1, 20, n);
    chk("abort_restart_done_cycles", n, 8);
    chk("abort_restart_pass", pass[1], 1'b1);

    // Randomized starts/words on inst 3 (L=3) against a timing/result model.
    cyc     = 0;
    done_at = 0;
    pend    = 1'b0;
    prev_rd = 1'b0;
    rdcnt   = 0;
    m_id    = EXP_ID;
    m_ts    = EXP_TS;
    for (int it = 0; it < 400; it++) begin
      if (pend && cyc > done_at) pend = 1'b0;
      if (!pend && $urandom_range(0, 3) == 0) begin
        id_w[3] = ($urandom_range(0, 1) == 1) ? EXP_ID : (EXP_ID ^ (32'h1 << $urandom_range(0, 31)));
        ts_w[3] = ($urandom_range(0, 1) == 1) ? EXP_TS : (EXP_TS ^ (32'h1 << $urandom_range(0, 31)));
      end
      start[3] = ($urandom_range(0, 3) == 0);
      if (start[3] && !pend) begin
        pend    = 1'b1;
        done_at = cyc + 4 + 2 * 3;
        m_id    = id_w[3];
        m_ts    = ts_w[3];
        rdcnt   = 0;
      end
      tick();
      cyc++;
      if (rd[3]) begin
        rdcnt++;
        chk("rand_read_gap", prev_rd, 1'b0);
      end
      prev_rd = rd[3];
      chk("rand_busy", busy[3], pend && (cyc <= done_at));
      chk("rand_done", done[3], pend && (cyc == done_at));
      if (pend && cyc == done_at) begin
        chk("rand_read_count", rdcnt, 2);
        chk("rand_id_value", id_v[3], m_id);
        chk("rand_ts_value", ts_v[3], m_ts);
        chk("rand_id_ok", id_ok[3], m_id == EXP_ID);
        chk("rand_ts_ok", ts_ok[3], m_ts == EXP_TS);
        chk("rand_pass", pass[3], (m_id == EXP_ID) && (m_ts == EXP_TS));
        chk("rand_valid", valid[3], 1'b1);
      end
    end
    start[3] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
